// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the mux-based scan serializer: state encoding,
// select width and the select start/end points for each scan direction.
package mux_scan_serializer_pkg;

    localparam int   SEL_W    = 3;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input logic msb_first);
        return msb_first ? 3'd0 : 3'd7;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_mux81.sv
// Legacy 8:1 bit multiplexer: out = I[S].
module mux81
    import mux_scan_serializer_pkg::*;
(
    input  logic [7:0]       I,
    input  logic [SEL_W-1:0] S,
    output logic             out
);

    // Select one of the eight data bits
    always_comb begin
        out = 1'b0;
        case (S)
            3'd0:    out = I[0];
            3'd1:    out = I[1];
            3'd2:    out = I[2];
            3'd3:    out = I[3];
            3'd4:    out = I[4];
            3'd5:    out = I[5];
            3'd6:    out = I[6];
            3'd7:    out = I[7];
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Captures a byte on a valid/ready handshake and scans it out one bit per beat
// through mux81, stepping the select up or down; counts completed words.
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [7:0]       load_data,
    input  logic             flush,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

    state_t             state_r, state_nxt_s;
    logic [7:0]         hold_r, hold_nxt_s;
    logic [SEL_W-1:0]   sel_r, sel_nxt_s;
    logic [CNT_W-1:0]   frame_cnt_r, frame_cnt_nxt_s;
    logic               load_ready_r, ser_valid_r, ser_last_r, busy_r;
    logic               mux_out_s;

    // Next-state logic; flush dominates any load or beat in the same cycle
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_r;
        sel_nxt_s       = sel_r;
        frame_cnt_nxt_s = frame_cnt_r;
        if (flush) begin
            state_nxt_s = S_IDLE;
            sel_nxt_s   = 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (load_valid) begin
                        state_nxt_s = S_SHIFT;
                        hold_nxt_s  = load_data;
                        sel_nxt_s   = SEL_START;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        if (sel_r == SEL_END) begin
                            state_nxt_s     = S_IDLE;
                            frame_cnt_nxt_s = frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            sel_nxt_s = MSB_FIRST ? (sel_r - 3'd1) : (sel_r + 3'd1);
                        end
                    end else begin
                        state_nxt_s = S_SHIFT;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    sel_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // State, datapath and handshake flags, all registered from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            hold_r       <= 8'h00;
            sel_r        <= 3'd0;
            frame_cnt_r  <= {CNT_W{1'b0}};
            load_ready_r <= 1'b1;
            ser_valid_r  <= 1'b0;
            ser_last_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            hold_r       <= hold_nxt_s;
            sel_r        <= sel_nxt_s;
            frame_cnt_r  <= frame_cnt_nxt_s;
            load_ready_r <= (state_nxt_s == S_IDLE);
            ser_valid_r  <= (state_nxt_s == S_SHIFT);
            ser_last_r   <= (state_nxt_s == S_SHIFT) && (sel_nxt_s == SEL_END);
            busy_r       <= (state_nxt_s == S_SHIFT);
        end
    end

    mux81 u_mux81 (
        .I   (hold_r),
        .S   (sel_r),
        .out (mux_out_s)
    );

    // The serial line is held low whenever no word is in flight
    assign ser_out    = mux_out_s & ser_valid_r;
    assign ser_valid  = ser_valid_r;
    assign ser_last   = ser_last_r;
    assign load_ready = load_ready_r;
    assign busy       = busy_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance share one stimulus stream.
module tb_mux_scan_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       flush;
    logic       ser_ready;

    logic       load_ready0, ser_out0, ser_valid0, ser_last0, busy0;
    logic       load_ready1, ser_out1, ser_valid1, ser_last1, busy1;
    logic [7:0] frame0, frame1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fc_exp   = 8'h00;

    always #5 clk = ~clk;

    mux_scan_serializer #(.MSB_FIRST(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .flush(flush), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .ser_ready(ser_ready), .ser_last(ser_last0), .busy(busy0), .frame_cnt(frame0)
    );

    mux_scan_serializer #(.MSB_FIRST(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .flush(flush), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .ser_ready(ser_ready), .ser_last(ser_last1), .busy(busy1), .frame_cnt(frame1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; flush = 1'b0; ser_ready = 1'b1;
        #2;
        n_checks++; if (load_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got %b exp 1", load_ready0); end
        n_checks++; if (ser_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid got %b exp 0", ser_valid0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy0); end
        n_checks++; if (frame0 !== 8'h00) begin n_fail++; $display("FAIL reset_frame got %0d exp 0", frame0); end
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_lsb_first;
        logic [7:0] w = 8'hEA;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick;
        load_valid = 1'b0; load_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ser_out0 !== w[i]) begin n_fail++; $display("FAIL lsb_bit%0d got %b exp %b", i, ser_out0, w[i]); end
            n_checks++; if (ser_last0 !== (i == 7)) begin n_fail++; $display("FAIL lsb_last%0d got %b exp %b", i, ser_last0, (i == 7)); end
            tick;
        end
        fc_exp = fc_exp + 8'd1;
        n_checks++; if (load_ready0 !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_ready got %b exp 1", load_ready0); end
        n_checks++; if (ser_valid0 !== 1'b0) begin n_fail++; $display("FAIL lsb_idle_valid got %b exp 0", ser_valid0); end
        n_checks++; if (frame0 !== fc_exp) begin n_fail++; $display("FAIL lsb_frame got %0d exp %0d", frame0, fc_exp); end
    endtask

    task automatic test_msb_first;
        logic [7:0] w = 8'hEA;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick;
        load_valid = 1'b0; load_data = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ser_out1 !== w[7-i]) begin n_fail++; $display("FAIL msb_bit%0d got %b exp %b", i, ser_out1, w[7-i]); end
            n_checks++; if (ser_last1 !== (i == 7)) begin n_fail++; $display("FAIL msb_last%0d got %b exp %b", i, ser_last1, (i == 7)); end
            tick;
        end
        fc_exp = fc_exp + 8'd1;
        n_checks++; if (load_ready1 !== 1'b1) begin n_fail++; $display("FAIL msb_idle_ready got %b exp 1", load_ready1); end
        n_checks++; if (frame1 !== fc_exp) begin n_fail++; $display("FAIL msb_frame got %0d exp %0d", frame1, fc_exp); end
    endtask

    task automatic test_reset_midword;
        load_valid = 1'b1; load_data = 8'hEA; ser_ready = 1'b1;
        tick;
        load_valid = 1'b0;
        tick; tick;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ser_valid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", ser_valid0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy0); end
        n_checks++; if (ser_out0 !== 1'b0) begin n_fail++; $display("FAIL midrst_out got %b exp 0", ser_out0); end
        n_checks++; if (ser_last1 !== 1'b0) begin n_fail++; $display("FAIL midrst_last got %b exp 0", ser_last1); end
        n_checks++; if (frame0 !== 8'h00) begin n_fail++; $display("FAIL midrst_frame got %0d exp 0", frame0); end
        tick;
        rst = 1'b0;
        tick;
        fc_exp = 8'h00;
        n_checks++; if (load_ready0 !== 1'b1) begin n_fail++; $display("FAIL postrst_ready got %b exp 1", load_ready0); end
        n_checks++; if (frame1 !== 8'h00) begin n_fail++; $display("FAIL postrst_frame got %0d exp 0", frame1); end
    endtask

    task automatic test_backpressure;
        logic [7:0] w = 8'hEA;
        int bit_idx = 0;
        int cycles  = 0;
        bit stalled = 1'b0;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick;
        load_valid = 1'b0;
        for (int g = 0; g < 30 && busy0 === 1'b1; g++) begin
            cycles++;
            n_checks++; if (ser_out0 !== w[bit_idx % 8]) begin n_fail++; $display("FAIL bp_bit%0d got %b exp %b", bit_idx, ser_out0, w[bit_idx % 8]); end
            n_checks++; if (ser_last0 !== (bit_idx == 7)) begin n_fail++; $display("FAIL bp_last%0d got %b exp %b", bit_idx, ser_last0, (bit_idx == 7)); end
            if (bit_idx >= 2 && bit_idx <= 4 && !stalled) begin
                ser_ready = 1'b0; stalled = 1'b1;
            end else begin
                ser_ready = 1'b1; stalled = 1'b0; bit_idx++;
            end
            tick;
        end
        ser_ready = 1'b1;
        fc_exp = fc_exp + 8'd1;
        n_checks++; if (bit_idx != 8) begin n_fail++; $display("FAIL bp_bits got %0d exp 8", bit_idx); end
        n_checks++; if (cycles != 11) begin n_fail++; $display("FAIL bp_cycles got %0d exp 11", cycles); end
        n_checks++; if (frame0 !== fc_exp) begin n_fail++; $display("FAIL bp_frame got %0d exp %0d", frame0, fc_exp); end
    endtask

    task automatic test_flush;
        logic [7:0] w = 8'h0F;
        load_valid = 1'b1; load_data = 8'hEA; ser_ready = 1'b1;
        tick;
        load_valid = 1'b0;
        tick; tick; tick; tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n_checks++; if (ser_valid0 !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", ser_valid0); end
        n_checks++; if (ser_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_valid1 got %b exp 0", ser_valid1); end
        n_checks++; if (frame0 !== fc_exp) begin n_fail++; $display("FAIL flush_frame got %0d exp %0d", frame0, fc_exp); end
        flush = 1'b1; load_valid = 1'b1; load_data = 8'h55;
        tick;
        flush = 1'b0;
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL flush_load_busy got %b exp 0", busy0); end
        n_checks++; if (load_ready0 !== 1'b1) begin n_fail++; $display("FAIL flush_load_ready got %b exp 1", load_ready0); end
        load_data = w;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (ser_out0 !== w[i]) begin n_fail++; $display("FAIL f0f_bit%0d got %b exp %b", i, ser_out0, w[i]); end
            n_checks++; if (ser_out1 !== w[7-i]) begin n_fail++; $display("FAIL f0f_msb_bit%0d got %b exp %b", i, ser_out1, w[7-i]); end
            tick;
        end
        fc_exp = fc_exp + 8'd1;
        n_checks++; if (frame0 !== fc_exp) begin n_fail++; $display("FAIL f0f_frame got %0d exp %0d", frame0, fc_exp); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        fc_exp = 8'h00;
        load_valid = 1'b1; ser_ready = 1'b1;
        for (int w = 0; w < 256; w++) begin
            d = 8'(w) ^ 8'h5A;
            n_checks++; if (load_ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_gap%0d got %b exp 1", w, load_ready0); end
            load_data = d;
            tick;
            n_checks++; if (ser_out0 !== d[0]) begin n_fail++; $display("FAIL b2b_first%0d got %b exp %b", w, ser_out0, d[0]); end
            n_checks++; if (ser_out1 !== d[7]) begin n_fail++; $display("FAIL b2b_first_msb%0d got %b exp %b", w, ser_out1, d[7]); end
            for (int b = 1; b < 8; b++) tick;
            n_checks++; if (ser_last0 !== 1'b1) begin n_fail++; $display("FAIL b2b_last%0d got %b exp 1", w, ser_last0); end
            tick;
            fc_exp = fc_exp + 8'd1;
            if (w == 254) begin
                n_checks++; if (frame0 !== 8'd255) begin n_fail++; $display("FAIL b2b_frame255 got %0d exp 255", frame0); end
            end
        end
        load_valid = 1'b0;
        n_checks++; if (frame0 !== 8'h00) begin n_fail++; $display("FAIL b2b_wrap got %0d exp 0", frame0); end
        n_checks++; if (frame1 !== fc_exp) begin n_fail++; $display("FAIL b2b_wrap_msb got %0d exp %0d", frame1, fc_exp); end
    endtask

    initial begin
        test_reset;
        test_lsb_first;
        test_msb_first;
        test_reset_midword;
        test_backpressure;
        test_flush;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
